mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter_if : fetch, load/store and memory bus bundle | rev 1.0
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        busy;
  logic        err;

  // The arbiter serves the requesters and drives the memory port.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
           busy, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
           busy, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter : fetch vs load/store arbiter for one memory port | rev 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TMO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                owner_dm, owner_dm_nxt;
  logic [STARVE_W-1:0] starve_cnt, starve_nxt;
  logic [TMO_W-1:0]    tmo_cnt, tmo_nxt, tmo_inc;
  logic                mem_en, mem_en_nxt;
  logic                mem_we, mem_we_nxt;
  logic [31:0]         mem_addr, mem_addr_nxt;
  logic [31:0]         mem_wdata, mem_wdata_nxt;
  logic [31:0]         if_rdata, if_rdata_nxt;
  logic [31:0]         dm_rdata, dm_rdata_nxt;
  logic                if_ack, if_ack_nxt;
  logic                dm_ack, dm_ack_nxt;
  logic                err, err_nxt;
  logic                busy, busy_nxt;
  logic                if_wins;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_dm   <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner_dm   <= owner_dm_nxt;
      starve_cnt <= starve_nxt;
      tmo_cnt    <= tmo_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_rdata   <= if_rdata_nxt;
      dm_rdata   <= dm_rdata_nxt;
      if_ack     <= if_ack_nxt;
      dm_ack     <= dm_ack_nxt;
      err        <= err_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_dm_nxt  = owner_dm;
    starve_nxt    = starve_cnt;
    tmo_nxt       = tmo_cnt;
    tmo_inc       = tmo_cnt + TMO_W'(1);
    mem_en_nxt    = mem_en;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;
    if_ack_nxt    = 1'b0;
    dm_ack_nxt    = 1'b0;
    err_nxt       = 1'b0;
    // Data side normally wins; a fetch that has waited out STARVE_LIMIT grants takes its turn.
    if_wins       = bus.if_req && (!bus.dm_req || (starve_cnt == STARVE_W'(STARVE_LIMIT)));

    case (state)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          state_nxt  = ACCESS;
          mem_en_nxt = 1'b1;
          tmo_nxt    = '0;
          if (if_wins) begin
            owner_dm_nxt  = 1'b0;
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = bus.if_addr;
            mem_wdata_nxt = '0;
            starve_nxt    = '0;
          end else begin
            owner_dm_nxt  = 1'b1;
            mem_we_nxt    = bus.dm_we;
            mem_addr_nxt  = bus.dm_addr;
            mem_wdata_nxt = bus.dm_wdata;
            if (bus.if_req && (starve_cnt != STARVE_W'(STARVE_LIMIT)))
              starve_nxt = starve_cnt + STARVE_W'(1);
          end
        end
      end

      ACCESS: begin
        if (bus.mem_ready) begin
          state_nxt  = RESP;
          mem_en_nxt = 1'b0;
          mem_we_nxt = 1'b0;
          if (owner_dm) begin
            dm_ack_nxt = 1'b1;
            if (!mem_we) dm_rdata_nxt = bus.mem_rdata;
          end else begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = bus.mem_rdata;
          end
        end else if (tmo_inc == TMO_W'(TIMEOUT)) begin
          // Abort: the owner gets its ack with err and zeroed read data.
          state_nxt  = RESP;
          tmo_nxt    = tmo_inc;
          mem_en_nxt = 1'b0;
          mem_we_nxt = 1'b0;
          err_nxt    = 1'b1;
          if (owner_dm) begin
            dm_ack_nxt   = 1'b1;
            dm_rdata_nxt = '0;
          end else begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = '0;
          end
        end else begin
          tmo_nxt = tmo_inc;
        end
      end

      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.if_rdata  = if_rdata;
  assign bus.dm_rdata  = dm_rdata;
  assign bus.if_ack    = if_ack;
  assign bus.dm_ack    = dm_ack;
  assign bus.err       = err;
  assign bus.busy      = busy;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter : directed + randomized bench with a transaction model | rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding transfer, counted in memory cycles.
  bit          m_active, m_resp, m_err, m_owner_dm, m_we;
  int          m_waited, m_streak;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;

  task automatic model_reset();
    m_active = 0; m_resp = 0; m_err = 0; m_owner_dm = 0; m_we = 0;
    m_waited = 0; m_streak = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
  endtask

  task automatic compare_outputs();
    bit en;
    en = m_active && !m_resp;
    chk("mem_en",    32'(bus.mem_en),   32'(en));
    chk("mem_we",    32'(bus.mem_we),   32'(en && m_we));
    chk("mem_addr",  bus.mem_addr,      m_addr);
    chk("mem_wdata", bus.mem_wdata,     m_wdata);
    chk("busy",      32'(bus.busy),     32'(m_active));
    chk("if_ack",    32'(bus.if_ack),   32'(m_resp && !m_owner_dm));
    chk("dm_ack",    32'(bus.dm_ack),   32'(m_resp && m_owner_dm));
    chk("err",       32'(bus.err),      32'(m_resp && m_err));
    chk("if_rdata",  bus.if_rdata,      m_if_rdata);
    chk("dm_rdata",  bus.dm_rdata,      m_dm_rdata);
  endtask

  task automatic model_advance();
    bit fetch_turn;
    if (m_resp) begin
      m_active = 0; m_resp = 0; m_err = 0;
    end else if (m_active) begin
      m_waited++;
      if (bus.mem_ready) begin
        m_resp = 1;
        if (m_owner_dm) begin
          if (!m_we) m_dm_rdata = bus.mem_rdata;
        end else begin
          m_if_rdata = bus.mem_rdata;
        end
      end else if (m_waited == TIMEOUT) begin
        m_resp = 1; m_err = 1;
        if (m_owner_dm) m_dm_rdata = '0;
        else            m_if_rdata = '0;
      end
    end else if (bus.if_req || bus.dm_req) begin
      fetch_turn = bus.if_req && (!bus.dm_req || m_streak >= STARVE_LIMIT);
      m_active = 1; m_waited = 0;
      if (fetch_turn) begin
        m_owner_dm = 0; m_we = 0; m_addr = bus.if_addr; m_wdata = '0; m_streak = 0;
      end else begin
        m_owner_dm = 1; m_we = bus.dm_we; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
        if (bus.if_req && m_streak < STARVE_LIMIT) m_streak++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      compare_outputs();
    end else begin
      compare_outputs();
      model_advance();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer: ready stays low for the first `stall` memory cycles.
  task automatic do_access(input int stall, output int en_cycles, output int steps,
                           output logic [31:0] addr0, output bit we0,
                           output bit ifa, output bit dma, output bit er);
    en_cycles = 0; steps = 0; addr0 = '0; we0 = 0; ifa = 0; dma = 0; er = 0;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      steps++;
      if (bus.mem_en) begin
        if (en_cycles == 0) begin
          addr0 = bus.mem_addr;
          we0   = bus.mem_we;
        end else begin
          chk("addr_stable", bus.mem_addr, addr0);
        end
        en_cycles++;
      end
      if (bus.if_ack || bus.dm_ack) begin
        ifa = bus.if_ack; dma = bus.dm_ack; er = bus.err;
        return;
      end
      bus.mem_ready = (en_cycles > stall);
    end
    checks++;
    failures++;
    $display("FAIL access_bound actual=no_ack required=ack_within_64_cycles at t=%0t", $time);
  endtask

  task automatic drive_requesters(input bit allow_new);
    if (bus.if_ack) begin
      bus.if_req  = allow_new && ($urandom_range(0, 1) == 1);
      bus.if_addr = $urandom;
    end else if (!bus.if_req && allow_new && $urandom_range(0, 3) == 0) begin
      bus.if_req  = 1'b1;
      bus.if_addr = $urandom;
    end
    if (bus.dm_ack) begin
      bus.dm_req   = allow_new && ($urandom_range(0, 1) == 1);
      bus.dm_we    = ($urandom_range(0, 1) == 1);
      bus.dm_addr  = $urandom;
      bus.dm_wdata = $urandom;
    end else if (!bus.dm_req && allow_new && $urandom_range(0, 2) == 0) begin
      bus.dm_req   = 1'b1;
      bus.dm_we    = ($urandom_range(0, 1) == 1);
      bus.dm_addr  = $urandom;
      bus.dm_wdata = $urandom;
    end
  endtask

  initial begin
    int          n, st;
    logic [31:0] a;
    bit          we0, ifa, dma, er, prev_en, drained;
    logic [31:0] glog[$];
    logic [31:0] gexp[6];

    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 0;
    repeat (3) step();
    chk("reset_busy",     32'(bus.busy),   32'd0);
    chk("reset_mem_addr", bus.mem_addr,    32'h0);
    rst = 1'b0;

    // Single fetch
    bus.if_req = 1; bus.if_addr = 32'h100; bus.mem_rdata = 32'h0050_0093;
    do_access(0, n, st, a, we0, ifa, dma, er);
    bus.if_req = 0;
    chk("fetch_en_cycles", 32'(n), 32'd1);
    chk("fetch_addr",      a, 32'h100);
    chk("fetch_ack_cycle", 32'(st), 32'd2);
    chk("fetch_if_ack",    32'({ifa, dma, er}), 32'b100);
    chk("fetch_rdata",     bus.if_rdata, 32'h0050_0093);
    step();
    chk("fetch_idle",      32'(bus.busy), 32'd0);

    // Collision: the store goes first, the fetch at the next IDLE
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h2000; bus.dm_wdata = 32'hCAFE_F00D;
    bus.mem_rdata = 32'hDEAD_BEEF;
    do_access(0, n, st, a, we0, ifa, dma, er);
    bus.dm_req = 0; bus.dm_we = 0;
    chk("coll_first_addr", a, 32'h2000);
    chk("coll_first_we",   32'(we0), 32'd1);
    chk("coll_first_ack",  32'({ifa, dma}), 32'b01);
    chk("coll_store_nocap", bus.dm_rdata, 32'h0);
    do_access(0, n, st, a, we0, ifa, dma, er);
    chk("coll_second_addr", a, 32'h104);
    chk("coll_second_ack",  32'({ifa, dma, we0}), 32'b100);
    chk("coll_second_lat",  32'(st), 32'd3);
    chk("coll_if_rdata",    bus.if_rdata, 32'hDEAD_BEEF);

    // Starvation: dm re-requests continuously while a fetch waits
    bus.if_req = 1; bus.if_addr = 32'h300;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h400;
    bus.mem_ready = 1; prev_en = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.mem_en && !prev_en) glog.push_back(bus.mem_addr);
      prev_en = bus.mem_en;
      if (bus.if_ack) bus.if_req = 0;
      if (bus.dm_ack && glog.size() >= 6) bus.dm_req = 0;
      if (!bus.dm_req && !bus.if_req) break;
    end
    gexp = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300, 32'h400};
    chk("starve_grants", 32'(glog.size()), 32'd6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("starve_order", glog[i], gexp[i]);
    step();

    // Wait states
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h500; bus.mem_rdata = 32'h1234;
    do_access(3, n, st, a, we0, ifa, dma, er);
    bus.dm_req = 0;
    chk("wait_en_cycles", 32'(n), 32'd4);
    chk("wait_ack_cycle", 32'(st), 32'd5);
    chk("wait_ack",       32'({ifa, dma, er}), 32'b010);
    chk("wait_rdata",     bus.dm_rdata, 32'h1234);
    step();

    // Timeout
    bus.dm_req = 1; bus.dm_addr = 32'h600; bus.mem_rdata = 32'h5555;
    do_access(1000, n, st, a, we0, ifa, dma, er);
    bus.dm_req = 0;
    chk("tmo_en_cycles", 32'(n), 32'd15);
    chk("tmo_ack_err",   32'({ifa, dma, er}), 32'b011);
    chk("tmo_rdata",     bus.dm_rdata, 32'h0);
    step();
    chk("tmo_idle",      32'({bus.busy, bus.err}), 32'b00);

    // Reset in the second ACCESS cycle
    bus.dm_req = 1; bus.dm_addr = 32'h700; bus.mem_ready = 0;
    step(); step();
    chk("pre_rst_en", 32'(bus.mem_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_en",   32'(bus.mem_en), 32'd0);
    chk("rst_async_busy", 32'(bus.busy),   32'd0);
    bus.dm_req = 0;
    step();
    chk("rst_no_ack", 32'({bus.if_ack, bus.dm_ack}), 32'b00);
    rst = 1'b0;
    bus.dm_req = 1; bus.dm_addr = 32'h704; bus.mem_rdata = 32'h77;
    do_access(1, n, st, a, we0, ifa, dma, er);
    bus.dm_req = 0;
    chk("post_rst_addr", a, 32'h704);
    chk("post_rst_lat",  32'({st[7:0], n[7:0]}), 32'h0302);
    chk("post_rst_ack",  32'({ifa, dma, er}), 32'b010);
    chk("post_rst_data", bus.dm_rdata, 32'h77);

    // Randomized traffic with normal, stall-heavy and fast memory phases
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int pct;
      pct = (cyc < 1200) ? 50 : (cyc < 2200) ? 3 : 90;
      step();
      drive_requesters(1'b1);
      bus.mem_ready = ($urandom_range(0, 99) < pct);
      bus.mem_rdata = $urandom;
    end

    drained = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      drive_requesters(1'b0);
      bus.mem_ready = 1'b1;
      if (!bus.if_req && !bus.dm_req && !bus.busy) begin
        drained = 1;
        break;
      end
    end
    chk("drain_done", 32'(drained), 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
